// File: rtl/div_xy8_if.sv
// div_xy8_if: start/busy/done handshake and operand/result bus for div_xy8.
// master drives start, x, y; slave returns busy, done, quotient, remainder, div_zero.
`timescale 1ns/1ps
interface div_xy8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, x, y,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, x, y,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_xy8.sv
// div_xy8: sequential restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (div_xy8_if.slave).
`timescale 1ns/1ps
module div_xy8 #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  div_xy8_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             divz_q;
  logic [WIDTH:0]   trial;

  // One bit wider than R so a negative result shows up in the MSB.
  always_comb begin
    trial = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt    <= '0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      divz_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            r_q    <= '0;
            q_q    <= bus.x;
            d_q    <= bus.y;
            cnt    <= '0;
            dz_q   <= (bus.y == '0);
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            r_q <= trial[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= {r_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          quo_q  <= q_q;
          rem_q  <= r_q;
          divz_q <= dz_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = divz_q;

endmodule

// File: tb/tb_div_xy8.sv
// tb_div_xy8: directed checks of div_xy8 latency, handshake and results.
// Immediate assertions at each comparison; one summary line at the end.
`timescale 1ns/1ps
module tb_div_xy8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   ndone;
  longint t_done;
  longint t_prev;

  div_xy8_if #(.WIDTH(8)) bus ();

  div_xy8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one op in IDLE (or the done cycle) and wait for its result.
  task automatic run_op(input string tag,
                        input logic [7:0] xv,
                        input logic [7:0] yv,
                        input logic [7:0] qe,
                        input logic [7:0] re,
                        input logic dze,
                        input bit hold);
    int k;
    bus.x = xv;
    bus.y = yv;
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_lo"}, 32'(bus.done), 32'd0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.done && k < 20);
    check({tag, "_lat"}, 32'(k), 32'd9);
    check({tag, "_q"}, 32'(bus.quotient), 32'(qe));
    check({tag, "_r"}, 32'(bus.remainder), 32'(re));
    check({tag, "_dz"}, 32'(bus.div_zero), 32'(dze));
    check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    t_done = $time;
    if (!hold) begin
      tick();
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 200/7 with explicit per-edge view.
    bus.x = 8'd200;
    bus.y = 8'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("basic_busy", 32'(bus.busy), 32'd1);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("basic_early_done", 32'(ndone), 32'd0);
    check("basic_busy_calc", 32'(bus.busy), 32'd1);
    tick();
    check("basic_done", 32'(bus.done), 32'd1);
    check("basic_q", 32'(bus.quotient), 32'd28);
    check("basic_r", 32'(bus.remainder), 32'd4);
    check("basic_dz", 32'(bus.div_zero), 32'd0);
    tick();
    check("basic_done_lo", 32'(bus.done), 32'd0);
    check("basic_hold_q", 32'(bus.quotient), 32'd28);

    // Back-to-back boundaries, start held through each done cycle.
    run_op("b2b_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b1);
    t_prev = t_done;
    run_op("b2b_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
    check("b2b_gap1", 32'(t_done - t_prev), 32'd100);
    t_prev = t_done;
    run_op("b2b_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1);
    check("b2b_gap2", 32'(t_done - t_prev), 32'd100);
    t_prev = t_done;
    run_op("b2b_0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b1);
    check("b2b_gap3", 32'(t_done - t_prev), 32'd100);
    bus.start = 1'b0;
    tick();
    check("b2b_done_lo", 32'(bus.done), 32'd0);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Divide by zero, then a normal op clears div_zero.
    run_op("dz_100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1'b0);
    run_op("dz_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);

    // Start and operand changes while busy are ignored.
    bus.x = 8'd77;
    bus.y = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        bus.start = 1'b1;
        bus.x = 8'd1;
        bus.y = 8'd1;
      end else begin
        bus.start = 1'b0;
        bus.x = 8'($urandom_range(255));
        bus.y = 8'($urandom_range(255));
      end
      if (i > 9) bus.start = 1'b0;
      tick();
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          check("ign_q", 32'(bus.quotient), 32'd15);
          check("ign_r", 32'(bus.remainder), 32'd2);
        end
      end
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_lat", 32'(lat), 32'd9);
    bus.start = 1'b0;

    // Reset in the middle of a calculation.
    bus.x = 8'd200;
    bus.y = 8'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_q", 32'(bus.quotient), 32'd0);
    check("mid_r", 32'(bus.remainder), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("mid_no_done", 32'(ndone), 32'd0);
    run_op("mid_50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b0);

    // Sampled sweep against a reference model.
    for (int xi = 0; xi < 256; xi += 17) begin
      for (int j = 0; j < 10; j++) begin
        logic [7:0] yy;
        logic [7:0] qm;
        logic [7:0] rm;
        logic [7:0] xx;
        logic [7:0] ytab [10];
        ytab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7,
                 8'd16, 8'd100, 8'd128, 8'd254, 8'd255};
        xx = 8'(xi);
        yy = ytab[j];
        if (yy == 8'd0) begin
          qm = 8'd255;
          rm = xx;
        end else begin
          qm = xx / yy;
          rm = xx % yy;
        end
        run_op("sweep", xx, yy, qm, rm, (yy == 8'd0), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
